// File: rtl/phase_sched_pkg.sv
// phase_sched_pkg
// Shared definitions for the two-channel phase_wrapper scheduler:
//   - sched_state_e : run/drain/idle controller encoding
//   - DW_DEFAULT    : default sample width
//   - LAT_MAX       : deepest wrapper latency the tag pipeline supports
//   - tag_t         : {valid, sel} channel tag carried beside each sample
//   - rr_pick()     : two-way round-robin pick over the holding slots
package phase_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam int DW_DEFAULT = 14;
    localparam int LAT_MAX    = 8;

    typedef struct packed {
        logic valid;
        logic sel;
    } tag_t;

    // Round-robin pick: a lone full slot wins outright; on a tie the slot
    // that did not win last time goes next.
    function automatic tag_t rr_pick(input logic [1:0] full, input logic last_grant);
        tag_t pick;
        pick.valid = 1'b0;
        pick.sel   = 1'b0;
        case (full)
            2'b00: begin
                pick.valid = 1'b0;
                pick.sel   = 1'b0;
            end
            2'b01: begin
                pick.valid = 1'b1;
                pick.sel   = 1'b0;
            end
            2'b10: begin
                pick.valid = 1'b1;
                pick.sel   = 1'b1;
            end
            2'b11: begin
                pick.valid = 1'b1;
                pick.sel   = ~last_grant;
            end
            default: begin
                pick.valid = 1'b0;
                pick.sel   = 1'b0;
            end
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/phase_wrap_scheduler_tag_delay_line.sv
// tag_delay_line
// Fixed-depth shift register carrying the {valid, sel} channel tag of each
// issued sample so that it lines up with the wrapper result LAT cycles later.
// Ports:
//   clk        system clock
//   clr_n      synchronous clear, active-low (empties every stage)
//   load_valid tag valid entering stage 1
//   load_sel   tag channel entering stage 1
//   last_valid tag valid at stage LAT
//   last_sel   tag channel at stage LAT
//   occupied   at least one stage holds a valid tag
module tag_delay_line
    import phase_sched_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic load_valid,
    input  logic load_sel,
    output logic last_valid,
    output logic last_sel,
    output logic occupied
);

    // Depth is kept within the supported range so an out-of-range
    // parameter cannot produce a zero-width or oversized vector.
    localparam int DEPTH = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] sel_r;

    // Tag shift register: stage 0 loads the issue strobe, later stages follow.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            valid_r <= {DEPTH{1'b0}};
            sel_r   <= {DEPTH{1'b0}};
        end else begin
            valid_r[0] <= load_valid;
            sel_r[0]   <= load_sel;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                sel_r[i]   <= sel_r[i-1];
            end
        end
    end

    assign last_valid = valid_r[DEPTH-1];
    assign last_sel   = sel_r[DEPTH-1];
    assign occupied   = |valid_r;

endmodule

// File: rtl/phase_wrap_scheduler.sv
// phase_wrap_scheduler
// Time-shares one phase_wrapper datapath between two ADC channels. Each
// channel has a one-sample holding slot; full slots are issued round-robin
// to the wrapper with a channel tag, the tag rides a LAT-deep delay line,
// and the wrapper result is steered back to the owning channel output.
// A run/drain/idle controller stops intake while letting held and
// in-flight samples finish.
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   enable_i               1 = accept samples, 0 = stop intake and drain
//   chN_data_i/valid_i     channel N sample in (signed, DW bits)
//   chN_ready_o            channel N slot can take a sample this cycle
//   wrp_data_o/valid_o     sample issued to the wrapper, one-cycle strobe
//   wrp_sel_o              channel tag of the issued sample
//   wrp_data_i             wrapper result, LAT cycles after wrp_valid_o
//   chN_data_o/valid_o     wrapped result for channel N, one-cycle strobe
//   busy_o                 controller is not idle
module phase_wrap_scheduler
    import phase_sched_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic          ch0_valid_i,
    output logic          ch0_ready_o,
    input  logic [DW-1:0] ch1_data_i,
    input  logic          ch1_valid_i,
    output logic          ch1_ready_o,
    output logic [DW-1:0] wrp_data_o,
    output logic          wrp_valid_o,
    output logic          wrp_sel_o,
    input  logic [DW-1:0] wrp_data_i,
    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    output logic          busy_o
);

    sched_state_e  state_r;
    logic          busy_r;
    logic [1:0]    full_r;
    logic [DW-1:0] hold0_r;
    logic [DW-1:0] hold1_r;
    logic          last_grant_r;
    logic [DW-1:0] wrp_data_r;
    logic          wrp_valid_r;
    logic          wrp_sel_r;
    logic [DW-1:0] ch0_data_r;
    logic          ch0_valid_r;
    logic [DW-1:0] ch1_data_r;
    logic          ch1_valid_r;

    tag_t          grant_s;
    logic          grant0_s;
    logic          grant1_s;
    logic [DW-1:0] grant_data_s;
    logic          run_s;
    logic          ready0_s;
    logic          ready1_s;
    logic          accept0_s;
    logic          accept1_s;
    logic          tag_valid_s;
    logic          tag_sel_s;
    logic          tag_occupied_s;
    logic          drain_done_s;

    // Grant is derived from registered slot state only, never from valid_i,
    // so ready_o carries no combinational path from the channel inputs.
    assign grant_s  = rr_pick(full_r, last_grant_r);
    assign grant0_s = grant_s.valid & ~grant_s.sel;
    assign grant1_s = grant_s.valid & grant_s.sel;

    // A slot being issued this cycle may be refilled at the same edge,
    // which lets a lone active channel stream at one sample per cycle.
    assign run_s     = (state_r == RUN);
    assign ready0_s  = run_s & (~full_r[0] | grant0_s);
    assign ready1_s  = run_s & (~full_r[1] | grant1_s);
    assign accept0_s = ch0_valid_i & ready0_s;
    assign accept1_s = ch1_valid_i & ready1_s;

    // Nothing left anywhere: both slots empty, no issue strobe pending,
    // and no tag still travelling alongside the wrapper.
    assign drain_done_s = (full_r == 2'b00) & ~wrp_valid_r & ~tag_occupied_s;

    // Selects the held sample of the granted channel.
    always_comb begin
        grant_data_s = hold0_r;
        if (grant_s.sel) begin
            grant_data_s = hold1_r;
        end else begin
            grant_data_s = hold0_r;
        end
    end

    // Run/drain/idle controller with busy registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable_i) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RUN;
                    end
                    busy_r <= 1'b1;
                end
                DRAIN: begin
                    // Re-enabling wins over completion; intake resumes at once.
                    if (enable_i) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else if (drain_done_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DRAIN;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Holding slots: fill on handshake, empty when issued unless refilled.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            full_r  <= 2'b00;
            hold0_r <= {DW{1'b0}};
            hold1_r <= {DW{1'b0}};
        end else begin
            if (accept0_s) begin
                hold0_r   <= ch0_data_i;
                full_r[0] <= 1'b1;
            end else if (grant0_s) begin
                full_r[0] <= 1'b0;
            end else begin
                full_r[0] <= full_r[0];
            end
            if (accept1_s) begin
                hold1_r   <= ch1_data_i;
                full_r[1] <= 1'b1;
            end else if (grant1_s) begin
                full_r[1] <= 1'b0;
            end else begin
                full_r[1] <= full_r[1];
            end
        end
    end

    // Issue stage: registers the granted sample and tag toward the wrapper.
    // Reset leaves last_grant at channel 1 so channel 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wrp_data_r   <= {DW{1'b0}};
            wrp_valid_r  <= 1'b0;
            wrp_sel_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            if (grant_s.valid) begin
                wrp_data_r   <= grant_data_s;
                wrp_valid_r  <= 1'b1;
                wrp_sel_r    <= grant_s.sel;
                last_grant_r <= grant_s.sel;
            end else begin
                wrp_valid_r  <= 1'b0;
            end
        end
    end

    tag_delay_line #(
        .LAT (LAT)
    ) u_tag_delay_line (
        .clk        (clk_i),
        .clr_n      (rst_i),
        .load_valid (wrp_valid_r),
        .load_sel   (wrp_sel_r),
        .last_valid (tag_valid_s),
        .last_sel   (tag_sel_s),
        .occupied   (tag_occupied_s)
    );

    // Result steering: only a live tag routes wrp_data_i to a channel, so
    // results left in the wrapper across a reset are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ch0_data_r  <= {DW{1'b0}};
            ch0_valid_r <= 1'b0;
            ch1_data_r  <= {DW{1'b0}};
            ch1_valid_r <= 1'b0;
        end else begin
            if (tag_valid_s && !tag_sel_s) begin
                ch0_data_r  <= wrp_data_i;
                ch0_valid_r <= 1'b1;
                ch1_valid_r <= 1'b0;
            end else if (tag_valid_s && tag_sel_s) begin
                ch1_data_r  <= wrp_data_i;
                ch1_valid_r <= 1'b1;
                ch0_valid_r <= 1'b0;
            end else begin
                ch0_valid_r <= 1'b0;
                ch1_valid_r <= 1'b0;
            end
        end
    end

    assign ch0_ready_o = ready0_s;
    assign ch1_ready_o = ready1_s;
    assign wrp_data_o  = wrp_data_r;
    assign wrp_valid_o = wrp_valid_r;
    assign wrp_sel_o   = wrp_sel_r;
    assign ch0_data_o  = ch0_data_r;
    assign ch0_valid_o = ch0_valid_r;
    assign ch1_data_o  = ch1_data_r;
    assign ch1_valid_o = ch1_valid_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_phase_wrap_scheduler.sv
// Testbench for phase_wrap_scheduler. Three instances (LAT = 1, 3, 4) share
// the same channel stimulus; each has its own register-chain wrapper model.
module tb_phase_wrap_scheduler;

    localparam int DW   = 14;
    localparam int NI   = 3;
    localparam int LOGN = 16;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [DW-1:0] c0d;
    logic [DW-1:0] c1d;
    logic          c0v;
    logic          c1v;

    logic          c0r  [NI];
    logic          c1r  [NI];
    logic [DW-1:0] wd   [NI];
    logic          wv   [NI];
    logic          ws   [NI];
    logic [DW-1:0] wi   [NI];
    logic [DW-1:0] o0d  [NI];
    logic          o0v  [NI];
    logic [DW-1:0] o1d  [NI];
    logic          o1v  [NI];
    logic          busy [NI];

    // output logs, filled once per cycle by tick()
    logic signed [DW-1:0] d0 [NI][LOGN];
    logic signed [DW-1:0] d1 [NI][LOGN];
    int                   t0 [NI][LOGN];
    int                   t1 [NI][LOGN];
    logic                 sl [NI][LOGN];
    int                   n0 [NI];
    int                   n1 [NI];
    int                   ni [NI];
    int                   fall [NI];
    logic                 busy_q [NI];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int acc0_first;
    int stall0;
    int drv_cycles;
    int d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
        logic [DW-1:0] pipe [L];

        phase_wrap_scheduler #(
            .DW  (DW),
            .LAT (L)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .enable_i    (enable),
            .ch0_data_i  (c0d),
            .ch0_valid_i (c0v),
            .ch0_ready_o (c0r[gi]),
            .ch1_data_i  (c1d),
            .ch1_valid_i (c1v),
            .ch1_ready_o (c1r[gi]),
            .wrp_data_o  (wd[gi]),
            .wrp_valid_o (wv[gi]),
            .wrp_sel_o   (ws[gi]),
            .wrp_data_i  (wi[gi]),
            .ch0_data_o  (o0d[gi]),
            .ch0_valid_o (o0v[gi]),
            .ch1_data_o  (o1d[gi]),
            .ch1_valid_o (o1v[gi]),
            .busy_o      (busy[gi])
        );

        // wrapper model: pure L-cycle delay of the issued data
        always @(posedge clk) begin
            pipe[0] <= wd[gi];
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign wi[gi] = pipe[L-1];
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NI; i++) begin
            n0[i] = 0;
            n1[i] = 0;
            ni[i] = 0;
            fall[i] = -1;
        end
    endtask

    // advance to the next falling edge and log every instance's outputs
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (o0v[i]) begin
                if (n0[i] < LOGN) begin
                    d0[i][n0[i]] = o0d[i];
                    t0[i][n0[i]] = cyc;
                end
                n0[i]++;
            end
            if (o1v[i]) begin
                if (n1[i] < LOGN) begin
                    d1[i][n1[i]] = o1d[i];
                    t1[i][n1[i]] = cyc;
                end
                n1[i]++;
            end
            if (wv[i]) begin
                if (ni[i] < LOGN) sl[i][ni[i]] = ws[i];
                ni[i]++;
            end
            if (busy_q[i] && !busy[i]) fall[i] = cyc;
            busy_q[i] = busy[i];
        end
    endtask

    // stream n0s/n1s samples (first + k*step) honouring ready, bounded
    task automatic drive(input int n0s, input int f0, input int s0,
                         input int n1s, input int f1, input int s1);
        int k0 = 0;
        int k1 = 0;
        drv_cycles = 0;
        stall0 = 0;
        acc0_first = -1;
        while ((k0 < n0s || k1 < n1s) && drv_cycles < 40) begin
            c0v = (k0 < n0s);
            c0d = DW'(f0 + k0 * s0);
            c1v = (k1 < n1s);
            c1d = DW'(f1 + k1 * s1);
            if (c0v && c0r[0]) begin
                if (k0 == 0) acc0_first = cyc;
                k0++;
            end else if (c0v) begin
                stall0++;
            end
            if (c1v && c1r[0]) k1++;
            tick();
            drv_cycles++;
        end
        c0v = 1'b0;
        c1v = 1'b0;
        check_eq("drive_done", k0 + k1, n0s + n1s);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        c0v = 1'b0;
        c1v = 1'b0;
        c0d = '0;
        c1d = '0;
        for (int i = 0; i < NI; i++) busy_q[i] = 1'b0;
        clear_logs();

        // reset state
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            check_eq("rst_outputs_zero",
                     int'(|{wv[i], ws[i], wd[i], o0v[i], o0d[i], o1v[i], o1d[i], busy[i]}), 0);
            check_eq("rst_ready_zero", int'(c0r[i] | c1r[i]), 0);
        end

        // single-channel stream 100, 300, 500
        rst = 1'b1;
        enable = 1'b1;
        tick();
        check_eq("run_busy", int'(busy[0]), 1);
        clear_logs();
        drive(3, 100, 200, 0, 0, 0);
        repeat (12) tick();
        check_eq("single_no_stall", stall0, 0);
        for (int i = 0; i < NI; i++) begin
            check_eq("single_n0", n0[i], 3);
            check_eq("single_n1", n1[i], 0);
            check_eq("single_latency", t0[i][0] - (acc0_first + 1), lat_of(i) + 2);
            check_eq("single_d0", int'(d0[i][0]), 100);
            check_eq("single_d1", int'(d0[i][1]), 300);
            check_eq("single_d2", int'(d0[i][2]), 500);
            check_eq("single_back2back", t0[i][2] - t0[i][0], 2);
        end

        // signed extremes on channel 1
        clear_logs();
        drive(0, 0, 0, 2, 8191, -16383);
        repeat (10) tick();
        for (int i = 0; i < NI; i++) begin
            check_eq("ext_n1", n1[i], 2);
            check_eq("ext_n0", n0[i], 0);
            check_eq("ext_max", int'(d1[i][0]), 8191);
            check_eq("ext_min", int'(d1[i][1]), -8192);
        end

        // reset with one sample issued and one held
        clear_logs();
        drive(2, 7, 1, 0, 0, 0);
        check_eq("rst_mid_inflight", int'(wv[1]), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            check_eq("rst_mid_zero",
                     int'(|{wv[i], ws[i], wd[i], o0v[i], o0d[i], o1v[i], o1d[i], busy[i]}), 0);
        end
        clear_logs();
        repeat (12) tick();
        for (int i = 0; i < NI; i++) begin
            check_eq("rst_mid_no_stale", n0[i] + n1[i], 0);
            check_eq("rst_mid_no_issue", ni[i], 0);
        end

        // contention: both channels streaming, first tie after reset to ch0
        clear_logs();
        drive(4, 10, 1, 4, -10, -1);
        repeat (14) tick();
        check_eq("cont_cycles", drv_cycles, 7);
        for (int i = 0; i < NI; i++) begin
            check_eq("cont_n0", n0[i], 4);
            check_eq("cont_n1", n1[i], 4);
            check_eq("cont_issues", ni[i], 8);
            for (int k = 0; k < 8; k++) check_eq("cont_sel", int'(sl[i][k]), k % 2);
            for (int k = 0; k < 4; k++) begin
                check_eq("cont_ch0", int'(d0[i][k]), 10 + k);
                check_eq("cont_ch1", int'(d1[i][k]), -10 - k);
            end
        end

        // drain: two held, one in flight when enable drops
        clear_logs();
        d = cyc;
        c0v = 1'b1;
        c0d = DW'(20);
        c1v = 1'b1;
        c1d = DW'(-20);
        check_eq("drain_rdy_pre", int'(c0r[0] & c1r[0]), 1);
        tick();
        c0d = DW'(21);
        c1v = 1'b0;
        check_eq("drain_refill_rdy", int'(c0r[0]), 1);
        tick();
        c0v = 1'b0;
        enable = 1'b0;
        check_eq("drain_inflight", int'(wv[0]), 1);
        tick();
        for (int i = 0; i < NI; i++) begin
            check_eq("drain_ready_low", int'(c0r[i] | c1r[i]), 0);
            check_eq("drain_busy", int'(busy[i]), 1);
        end
        repeat (16) tick();
        for (int i = 0; i < NI; i++) begin
            check_eq("drain_n0", n0[i], 2);
            check_eq("drain_n1", n1[i], 1);
            check_eq("drain_d0a", int'(d0[i][0]), 20);
            check_eq("drain_d0b", int'(d0[i][1]), 21);
            check_eq("drain_d1", int'(d1[i][0]), -20);
            check_eq("drain_t_ch1", t1[i][0], d + 4 + lat_of(i));
            check_eq("drain_t_last", t0[i][1], d + 5 + lat_of(i));
            check_eq("drain_busy_fall", fall[i], d + 6 + lat_of(i));
            check_eq("drain_idle", int'(busy[i]), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
